axi4_to_axi4_stream: RTL
========================

Name: axi4_to_axi4_stream

Overview:
Read-side counterpart of the frame buffer's stream-to-memory writer. It accepts a read request (byte address and packet size in bytes) and issues AXI4 INCR read bursts of at most 256 beats. It then re-emits the returned read data as one AXI4-Stream packet with tlast on the final word and a byte mask on a partial final word. It sits between the frame buffer's AXI4 memory port and the downstream video/packet consumer.

Parameters:
DATA_WIDTH, 64, AXI data width in bits; also the stream tdata width.
ADDR_WIDTH, 32, AXI address width.
ID_WIDTH, 1, AXI ID width; all IDs are driven to 0.
AWUSER_WIDTH / WUSER_WIDTH / ARUSER_WIDTH, 1, AXI user widths; all driven to 0.
MAX_PKT_SIZE_B, 2048, maximum packet size in bytes.
MAX_PKT_SIZE_WIDTH, $clog2(MAX_PKT_SIZE_B), width of pkt_size_i.

Ports:
clk_i  input  1  clock
rst_n_i  input  1  synchronous reset, active-low
req_valid_i  input  1  read request valid
req_ready_o  output  1  request accepted when req_valid_i && req_ready_o
addr_i  input  ADDR_WIDTH  packet start byte address; low log2(DATA_WIDTH/8) bits are ignored
pkt_size_i  input  MAX_PKT_SIZE_WIDTH  packet size in bytes
busy_o  output  1  high from request acceptance until the last stream beat handshakes
rresp_err_o  output  1  one-cycle pulse on any R beat with rresp != OKAY
pkt_o  axi4_stream_if.master  -  output packet stream
mem_o  axi4_if.master  -  AXI4 memory port (read channels used)

Interface decision:
- One clock; reset is synchronous and active-low. The clock port is clk_i and the reset port is rst_n_i.

Behaviour:
- Word math, with W = DATA_WIDTH/8:
  - pkt_words = ceil(pkt_size_i / W), computed as (pkt_size_i >> log2 W) + (low bits != 0).
  - rem = pkt_size_i[log2 W - 1 : 0].
  - cur_addr is addr_i aligned down to W.
  - All three are latched on request acceptance.
- States: IDLE, CALC_BURST, ADDR, DATA.
- IDLE:
  - req_ready_o = 1.
  - On accept with pkt_words != 0, go to CALC_BURST.
  - On accept with pkt_size_i == 0: stay in IDLE, no AXI traffic, no stream beat.
- CALC_BURST (1 cycle):
  - Burst length is 256 beats if words_left > 256, else words_left beats.
  - Register arlen = len-1, araddr = cur_addr, burst_left = len-1.
  - Next state is ADDR.
- ADDR:
  - arvalid = 1 until arready.
  - On AR handshake: cur_addr += len*W, then go to DATA.
  - At most one burst is outstanding at a time.
- DATA:
  - rready = pkt_o.tready; pkt_o.tvalid = rvalid; tdata = rdata.
  - Each handshake decrements words_left and burst_left.
  - On the beat with burst_left == 0 (rlast is expected there; rlast is ignored): if words_left == 1, go to IDLE, else go to CALC_BURST.
- Stream sideband:
  - tlast = 1 only on the packet's final word.
  - tstrb = tkeep = all ones, except on the final word when rem != 0, where it is (1<<rem)-1 (low rem bytes).
  - tid, tdest and tuser are driven to 0.
- Unused write channels: awvalid = 0, wvalid = 0, bready = 1. All AR constants: arsize = log2 W, arburst = INCR, all other AR fields 0.
- req_ready_o is 0 in every state other than IDLE. A request presented while busy is held off and never dropped.
- Reset (rst_n_i low at a clock edge), from any state including mid-burst:
  - state returns to IDLE.
  - arvalid = 0, araddr = 0, arlen = 0.
  - All counters are cleared.
  - busy_o = 0, rresp_err_o = 0.
  - An outstanding burst is abandoned; the interconnect must also be reset.
- Latency: accept at cycle 0, CALC_BURST at cycle 1, arvalid asserted at cycle 2. First tvalid follows the first rvalid combinationally.
- Bursts are not split at 4 KB boundaries. Callers must supply addresses that keep bursts within 4 KB, which is the same rule the writer imposes.

Decomposition:
- Shared package frame_buffer_pkg holds:
  - the AXI constants (BURST_INCR, RESP_OKAY, MAX_BURST_BEATS = 256);
  - a function words_from_bytes(size, W);
  - a function last_strb(rem, W).
- The writer shares these constants and functions.
- No sub-module: the FSM, counters and stream mux stay in one file.

Test Plan:
- Single short packet (DATA_WIDTH=64): addr 0x1003, size 20 -> one AR at araddr 0x1000, arlen 2; three stream beats; tlast on beat 3 with tstrb 0x0F, beats 1-2 with tstrb 0xFF.
- Exactly one full burst (MAX_PKT_SIZE_B=8192): size 2048 -> arlen 255, 256 beats, tlast only on beat 256 with tstrb 0xFF.
- Multi-burst (MAX_PKT_SIZE_B=8192): size 4100 at 0x0 -> AR pairs (0x0, 255), (0x800, 255), (0x1000, 0); 513 beats; final tstrb 0x0F.
- Backpressure and stalls: random tready and arready/rvalid gaps on size 100 -> rready tracks tready exactly, no beat lost or duplicated, data order preserved.
- Zero size and error: size 0 -> no arvalid, req_ready_o stays 1. A beat with rresp = SLVERR -> one-cycle rresp_err_o pulse while the packet still completes.
- Reset mid-DATA: assert rst_n_i low during beat 5 of a 3-burst read -> next cycle state is IDLE with req_ready_o 1, arvalid 0, busy_o 0; a new request then completes normally.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared AXI constants and word/strobe helpers for the frame buffer reader and writer.
// Latency: n/a (constants and combinational functions only).
// Backpressure: n/a.
package frame_buffer_pkg;

    localparam logic [1:0]  BURST_INCR      = 2'b01;
    localparam logic [1:0]  RESP_OKAY       = 2'b00;
    localparam int unsigned MAX_BURST_BEATS = 256;
    localparam int unsigned MAX_STRB_W      = 128;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC_BURST,
        S_ADDR,
        S_DATA
    } rd_state_e;

    // Number of bus words needed to carry size bytes; w is a power of two.
    function automatic int unsigned words_from_bytes(input int unsigned size, input int unsigned w);
        return (size / w) + (((size % w) != 0) ? 32'd1 : 32'd0);
    endfunction

    // Byte mask for the final word: low rem bytes, or all w bytes when rem is zero.
    function automatic logic [MAX_STRB_W-1:0] last_strb(input int unsigned rem, input int unsigned w);
        logic [MAX_STRB_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_STRB_W; i++) begin
            if ((i < w) && ((rem == 0) || (i < rem))) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 memory-mapped bundle (all five channels) for the frame buffer memory port.
// Latency: n/a (wires only).
// Backpressure: standard per-channel valid/ready.
interface axi4_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int ID_WIDTH     = 1,
    parameter int AWUSER_WIDTH = 1,
    parameter int WUSER_WIDTH  = 1,
    parameter int ARUSER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic [AWUSER_WIDTH-1:0] awuser;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic [WUSER_WIDTH-1:0]  wuser;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic [ARUSER_WIDTH-1:0] aruser;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
               awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
               arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
               aruser, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle between the frame buffer reader and its packet consumer.
// Latency: n/a (wires only).
// Backpressure: tready from the slave stalls the master.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axi4_to_axi4_stream.sv
// Reads a packet from memory with AXI4 INCR bursts (<=256 beats) and emits it as one AXI4-Stream packet.
// Latency: accept -> arvalid in 2 cycles; tvalid follows rvalid combinationally.
// Backpressure: rready is tready while in the data phase; new requests are held off until idle.
module axi4_to_axi4_stream
    import frame_buffer_pkg::*;
#(
    parameter int DATA_WIDTH         = 64,
    parameter int ADDR_WIDTH         = 32,
    parameter int ID_WIDTH           = 1,
    parameter int AWUSER_WIDTH       = 1,
    parameter int WUSER_WIDTH        = 1,
    parameter int ARUSER_WIDTH       = 1,
    parameter int MAX_PKT_SIZE_B     = 2048,
    parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_i,
    output logic                          busy_o,
    output logic                          rresp_err_o,
    axi4_stream_if.master                 pkt_o,
    axi4_if.master                        mem_o
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int ALIGN   = $clog2(STRB_W);
    localparam int WORDS_W = MAX_PKT_SIZE_WIDTH;

    rd_state_e             state_q;
    logic [WORDS_W-1:0]    words_left_q;
    logic [ALIGN-1:0]      rem_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic [7:0]            burst_left_q;
    logic                  arvalid_q;
    logic                  rresp_err_q;

    logic [WORDS_W-1:0]    req_words_d;
    logic [8:0]            burst_len_d;
    logic                  r_hs;
    logic                  in_data;
    logic                  final_word;
    logic [STRB_W-1:0]     final_strb;
    logic                  unused_in;

    assign req_words_d = WORDS_W'(words_from_bytes(32'(pkt_size_i), STRB_W));
    assign burst_len_d = (32'(words_left_q) > MAX_BURST_BEATS) ? 9'(MAX_BURST_BEATS) : 9'(words_left_q);
    assign in_data     = (state_q == S_DATA);
    assign r_hs        = in_data && mem_o.rvalid && pkt_o.tready;
    assign final_word  = in_data && (words_left_q == WORDS_W'(1));
    assign final_strb  = STRB_W'(last_strb(32'(rem_q), STRB_W));

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign rresp_err_o = rresp_err_q;

    // Stream side is a straight pass-through of R with packet-level sideband.
    assign pkt_o.tvalid = in_data && mem_o.rvalid;
    assign pkt_o.tdata  = mem_o.rdata;
    assign pkt_o.tlast  = final_word;
    assign pkt_o.tstrb  = final_word ? final_strb : '1;
    assign pkt_o.tkeep  = final_word ? final_strb : '1;
    assign pkt_o.tid    = '0;
    assign pkt_o.tdest  = '0;
    assign pkt_o.tuser  = '0;

    // Read channels; the write side is parked.
    assign mem_o.arid     = ID_WIDTH'(0);
    assign mem_o.araddr   = araddr_q;
    assign mem_o.arlen    = arlen_q;
    assign mem_o.arsize   = 3'(ALIGN);
    assign mem_o.arburst  = BURST_INCR;
    assign mem_o.arlock   = 1'b0;
    assign mem_o.arcache  = '0;
    assign mem_o.arprot   = '0;
    assign mem_o.arqos    = '0;
    assign mem_o.arregion = '0;
    assign mem_o.aruser   = ARUSER_WIDTH'(0);
    assign mem_o.arvalid  = arvalid_q;
    assign mem_o.rready   = in_data && pkt_o.tready;

    assign mem_o.awid     = ID_WIDTH'(0);
    assign mem_o.awaddr   = '0;
    assign mem_o.awlen    = '0;
    assign mem_o.awsize   = '0;
    assign mem_o.awburst  = '0;
    assign mem_o.awlock   = 1'b0;
    assign mem_o.awcache  = '0;
    assign mem_o.awprot   = '0;
    assign mem_o.awqos    = '0;
    assign mem_o.awregion = '0;
    assign mem_o.awuser   = AWUSER_WIDTH'(0);
    assign mem_o.awvalid  = 1'b0;
    assign mem_o.wdata    = '0;
    assign mem_o.wstrb    = '0;
    assign mem_o.wlast    = 1'b0;
    assign mem_o.wuser    = WUSER_WIDTH'(0);
    assign mem_o.wvalid   = 1'b0;
    assign mem_o.bready   = 1'b1;

    // rlast is not trusted: the burst end comes from our own beat counter.
    assign unused_in = ^{mem_o.rid, mem_o.rlast, mem_o.awready, mem_o.wready,
                         mem_o.bid, mem_o.bresp, mem_o.bvalid};

    // Request/burst FSM: latch the request, issue one burst at a time, count beats home.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            rem_q        <= '0;
            cur_addr_q   <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            burst_left_q <= '0;
            arvalid_q    <= 1'b0;
            rresp_err_q  <= 1'b0;
        end else begin
            rresp_err_q <= r_hs && (mem_o.rresp != RESP_OKAY);
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        words_left_q <= req_words_d;
                        rem_q        <= pkt_size_i[ALIGN-1:0];
                        cur_addr_q   <= addr_i & ~ADDR_WIDTH'(STRB_W - 1);
                        // A zero-byte request is consumed without any bus activity.
                        if (req_words_d != '0) begin
                            state_q <= S_CALC_BURST;
                        end
                    end
                end
                S_CALC_BURST: begin
                    arlen_q      <= 8'(burst_len_d - 9'd1);
                    burst_left_q <= 8'(burst_len_d - 9'd1);
                    araddr_q     <= cur_addr_q;
                    arvalid_q    <= 1'b1;
                    state_q      <= S_ADDR;
                end
                S_ADDR: begin
                    if (mem_o.arready) begin
                        arvalid_q  <= 1'b0;
                        cur_addr_q <= cur_addr_q + ((ADDR_WIDTH'(arlen_q) + ADDR_WIDTH'(1)) << ALIGN);
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_hs) begin
                        words_left_q <= words_left_q - WORDS_W'(1);
                        burst_left_q <= burst_left_q - 8'd1;
                        if (burst_left_q == 8'd0) begin
                            state_q <= (words_left_q == WORDS_W'(1)) ? S_IDLE : S_CALC_BURST;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
